// File: rtl/green_cpu_pkg.sv
// Shared constants for the Green CPU control path: opcodes, ALUOp codes and FSM states.
package green_cpu_pkg;

   localparam int unsigned OPC_W   = 4;
   localparam int unsigned ALUOP_W = 2;

   localparam logic [OPC_W-1:0] OPC_RTYPE = 4'b0000;
   localparam logic [OPC_W-1:0] OPC_LH    = 4'b1000;
   localparam logic [OPC_W-1:0] OPC_SH    = 4'b1001;
   localparam logic [OPC_W-1:0] OPC_HALT  = 4'b1110;
   localparam logic [OPC_W-1:0] OPC_NOP   = 4'b1111;

   localparam logic [ALUOP_W-1:0] OP_MEMORY = 2'b00;
   localparam logic [ALUOP_W-1:0] OP_RTYPE  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
      return opc inside {OPC_RTYPE, OPC_LH, OPC_SH, OPC_HALT, OPC_NOP};
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-handshake wait timer; tc marks the (2**TIMEOUT_W-1)th consecutive wait cycle.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT_W = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count,
   output logic tc
);

   localparam logic [TIMEOUT_W-1:0] TC_VAL = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

   logic [TIMEOUT_W-1:0] cnt;

   // cnt holds the number of wait cycles already spent in the current state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (count) begin
         cnt <= cnt + TIMEOUT_W'(1);
      end
   end

   assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the Green CPU with memory timeout and HALT.
module cpu_ctrl_fsm
   import green_cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT_W = 4,
   parameter int unsigned RETIRE_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                wake,
   input  logic [OPC_W-1:0]    opcode,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   output logic                imem_req,
   output logic                ir_load,
   output logic                pc_inc,
   output logic                rf_re,
   output logic                alu_en,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic                rf_we,
   output logic                wb_sel,
   output logic                halted,
   output logic                illegal_op,
   output logic                bus_err,
   output logic [RETIRE_W-1:0] retired
);

   state_t           state, state_d;
   logic [OPC_W-1:0] op_q, op_d;
   logic             retire_d, ill_d, berr_d;
   logic             wait_cnt, wait_clr, wait_tc;

   assign ir_load = (state == S_FETCH) && imem_ready;
   assign pc_inc  = ir_load;

   mem_wait_timer #(.TIMEOUT_W(TIMEOUT_W)) u_wait_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (wait_clr),
      .count (wait_cnt),
      .tc    (wait_tc)
   );

   // Next state, opcode latch and event strobes
   always_comb begin
      state_d  = state;
      op_d     = op_q;
      retire_d = 1'b0;
      ill_d    = 1'b0;
      berr_d   = 1'b0;
      wait_cnt = 1'b0;
      case (state)
         S_IDLE: if (start) state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ready) begin
               state_d = S_DECODE;
            end else begin
               wait_cnt = 1'b1;
               if (wait_tc) begin
                  berr_d  = 1'b1;
                  state_d = S_HALT;
               end
            end
         end
         S_DECODE: begin
            op_d = opcode;
            if (!opc_legal(opcode)) begin
               ill_d   = 1'b1;
               state_d = S_HALT;
            end else if (opcode == OPC_NOP) begin
               retire_d = 1'b1;
               state_d  = S_FETCH;
            end else if (opcode == OPC_HALT) begin
               retire_d = 1'b1;
               state_d  = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: state_d = (op_q == OPC_RTYPE) ? S_WB : S_MEM;
         S_MEM: begin
            if (dmem_ready) begin
               if (op_q == OPC_LH) begin
                  state_d = S_WB;
               end else begin
                  retire_d = 1'b1;
                  state_d  = S_FETCH;
               end
            end else begin
               wait_cnt = 1'b1;
               if (wait_tc) begin
                  berr_d  = 1'b1;
                  state_d = S_HALT;
               end
            end
         end
         S_WB: begin
            retire_d = 1'b1;
            state_d  = S_FETCH;
         end
         S_HALT: if (wake) state_d = S_FETCH;
         default: state_d = S_IDLE;
      endcase
      wait_clr = ~wait_cnt;
   end

   // Outputs are registered from the next state so they always decode the current state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         op_q       <= '0;
         retired    <= '0;
         illegal_op <= 1'b0;
         bus_err    <= 1'b0;
         imem_req   <= 1'b0;
         rf_re      <= 1'b0;
         alu_en     <= 1'b0;
         alu_op     <= OP_MEMORY;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         rf_we      <= 1'b0;
         wb_sel     <= 1'b0;
         halted     <= 1'b0;
      end else begin
         state      <= state_d;
         op_q       <= op_d;
         if (retire_d) retired <= retired + RETIRE_W'(1);
         illegal_op <= illegal_op | ill_d;
         bus_err    <= bus_err | berr_d;
         imem_req   <= (state_d == S_FETCH);
         rf_re      <= (state_d == S_DECODE);
         alu_en     <= (state_d == S_EXEC);
         alu_op     <= ((state_d == S_EXEC) && (op_d == OPC_RTYPE)) ? OP_RTYPE : OP_MEMORY;
         dmem_req   <= (state_d == S_MEM);
         dmem_we    <= (state_d == S_MEM) && (op_d == OPC_SH);
         rf_we      <= (state_d == S_WB);
         wb_sel     <= (state_d == S_WB) && (op_d == OPC_LH);
         halted     <= (state_d == S_HALT);
      end
   end

endmodule
